// File: rtl/rock_pkg.sv
// rock_pkg: shared types for the rocking controller.
// Holds the FSM state enum, its encoding constants and a saturating
// one-LSB step helper used by both slew-limited outputs.
// Optional heart tracking in rock_controller is enabled by ROCK_HEART_TRACK_EN.
package rock_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_RAMP_UP   = 2'd1;
    localparam logic [1:0] ST_ROCK      = 2'd2;
    localparam logic [1:0] ST_RAMP_DOWN = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        RAMP_UP   = ST_RAMP_UP,
        ROCK      = ST_ROCK,
        RAMP_DOWN = ST_RAMP_DOWN
    } rock_state_t;

    // Move cur one LSB toward tgt; never overshoots, never wraps.
    function automatic int unsigned step_toward(input int unsigned cur, input int unsigned tgt);
        if (cur < tgt) begin
            return cur + 1;
        end else if (cur > tgt) begin
            return cur - 1;
        end
        return cur;
    endfunction

endpackage

// File: rtl/rock_if.sv
// rock_if: stream/control bundle between the cry/heart front-ends, the
// rocking controller and the output stage.
//   vol_valid, vol   : cry-volume sample strobe and value
//   heart_pulse      : one-cycle pulse per heartbeat
//   enable           : rocking permitted
//   amp, rock_per    : amplitude and rocking-period codes to the output stage
//   state, active    : controller FSM state and non-idle flag
// master drives the inputs and observes outputs; slave is the controller.
interface rock_if #(
    parameter int unsigned VOL_W = 8,
    parameter int unsigned AMP_W = 8,
    parameter int unsigned PER_W = 8
) ();
    import rock_pkg::*;

    logic             vol_valid;
    logic [VOL_W-1:0] vol;
    logic             heart_pulse;
    logic             enable;
    logic [AMP_W-1:0] amp;
    logic [PER_W-1:0] rock_per;
    rock_state_t      state;
    logic             active;

    modport master (
        output vol_valid, vol, heart_pulse, enable,
        input  amp, rock_per, state, active
    );

    modport slave (
        input  vol_valid, vol, heart_pulse, enable,
        output amp, rock_per, state, active
    );

endinterface

// File: rtl/heart_period_meter.sv
// heart_period_meter: measures clk cycles between consecutive heart pulses.
//   clk, reset    : clock, asynchronous active-high reset
//   heart_pulse   : one-cycle pulse per heartbeat
//   period        : last measured pulse-to-pulse interval in clk cycles
//   period_valid  : period holds a measurement taken without saturation
// The counter saturates at all-ones, which invalidates the measurement and
// disarms the meter; two fresh pulses are then needed. A pulse coinciding
// with saturation wins.
module heart_period_meter #(
    parameter int unsigned HP_W = 24
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            heart_pulse,
    output logic [HP_W-1:0] period,
    output logic            period_valid
);

    logic [HP_W-1:0] cnt;
    logic            armed;  // a pulse was seen since reset/saturation

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            armed        <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
        end else if (heart_pulse) begin
            if (armed) begin
                period       <= cnt;
                period_valid <= 1'b1;
            end
            armed <= 1'b1;
            cnt   <= HP_W'(1);
        end else if (&cnt) begin
            armed        <= 1'b0;
            period_valid <= 1'b0;
        end else begin
            cnt <= cnt + HP_W'(1);
        end
    end

endmodule

// File: rtl/rock_controller.sv
// rock_controller: turns cry-volume samples and heartbeat pulses into
// slew-limited amplitude and rocking-period codes.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : rock_if.slave (vol_valid/vol, heart_pulse, enable in;
//                amp, rock_per, state, active out)
// Define ROCK_HEART_TRACK_EN to build heart_period_meter and track the
// rocking period from the heart rate; otherwise rock_per stays PER_FIXED.
module rock_controller
    import rock_pkg::*;
#(
    parameter int unsigned      VOL_W        = 8,
    parameter int unsigned      AMP_W        = 8,
    parameter int unsigned      PER_W        = 8,
    parameter logic [AMP_W-1:0] AMP_MAX      = 8'd200,
    parameter logic [VOL_W-1:0] CRY_THRESH   = 8'd64,
    parameter int unsigned      CALM_SAMPLES = 16,
    parameter int unsigned      STEP_DIV     = 1024,
    parameter logic [PER_W-1:0] PER_FIXED    = 8'd32,
    parameter logic [PER_W-1:0] PER_MIN      = 8'd8,
    parameter int unsigned      HP_W         = 24,
    parameter int unsigned      PER_SHIFT    = 16
) (
    input logic   clk,
    input logic   reset,
    rock_if.slave bus
);

    localparam int unsigned TICK_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned CALM_W = $clog2(CALM_SAMPLES + 1);

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [CALM_W-1:0] calm_cnt;
    logic [CALM_W-1:0] calm_nxt;
    logic              cry;
    logic              calm_sat;
    rock_state_t       state_q;
    logic [AMP_W-1:0]  amp_q;
    logic [AMP_W-1:0]  amp_tgt;
    logic [PER_W-1:0]  per_q;
    logic [PER_W-1:0]  per_tgt;
    logic              active_q;

    // Slew tick: free-running divider.
    assign tick = (tick_cnt == TICK_W'(STEP_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // Cry detection and calm hysteresis. The FSM looks at the next calm count
    // so a saturating strobe moves the state one cycle after the strobe.
    always_comb begin
        cry      = bus.vol_valid && (bus.vol >= CRY_THRESH);
        calm_nxt = calm_cnt;
        if (bus.vol_valid) begin
            if (cry) begin
                calm_nxt = '0;
            end else if (calm_cnt != CALM_W'(CALM_SAMPLES)) begin
                calm_nxt = calm_cnt + CALM_W'(1);
            end
        end
        calm_sat = (calm_nxt == CALM_W'(CALM_SAMPLES));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            calm_cnt <= '0;
        end else begin
            calm_cnt <= calm_nxt;
        end
    end

    assign amp_tgt = (state_q == RAMP_UP || state_q == ROCK) ? AMP_MAX : '0;

`ifdef ROCK_HEART_TRACK_EN
    logic [HP_W-1:0] hp_period;
    logic [HP_W-1:0] hp_code;
    logic            hp_valid;

    heart_period_meter #(
        .HP_W (HP_W)
    ) u_meter (
        .clk          (clk),
        .reset        (reset),
        .heart_pulse  (bus.heart_pulse),
        .period       (hp_period),
        .period_valid (hp_valid)
    );

    // Clamp compare is done at 32 bits; HP_W is expected to be <= 32.
    always_comb begin
        hp_code = hp_period >> PER_SHIFT;
        per_tgt = PER_FIXED;
        if (hp_valid) begin
            if (32'(hp_code) < 32'(PER_MIN)) begin
                per_tgt = PER_MIN;
            end else if (32'(hp_code) > 32'({PER_W{1'b1}})) begin
                per_tgt = {PER_W{1'b1}};
            end else begin
                per_tgt = PER_W'(hp_code);
            end
        end
    end
`else
    logic unused_track;
    assign unused_track = ^{bus.heart_pulse, PER_MIN, 32'(HP_W), 32'(PER_SHIFT)};
    assign per_tgt      = PER_FIXED;
`endif

    // Rocking FSM with registered amp/rock_per/active outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            amp_q    <= '0;
            per_q    <= PER_FIXED;
            active_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.enable && cry) begin
                        state_q  <= RAMP_UP;
                        active_q <= 1'b1;
                    end
                end
                RAMP_UP: begin
                    if (!bus.enable || calm_sat) begin
                        state_q <= RAMP_DOWN;
                    end else if (amp_q == AMP_MAX) begin
                        state_q <= ROCK;
                    end
                end
                ROCK: begin
                    if (!bus.enable || calm_sat) begin
                        state_q <= RAMP_DOWN;
                    end
                end
                RAMP_DOWN: begin
                    if (bus.enable && cry) begin
                        state_q <= RAMP_UP;
                    end else if (amp_q == '0) begin
                        state_q  <= IDLE;
                        active_q <= 1'b0;
                    end
                end
            endcase
            if (tick) begin
                amp_q <= AMP_W'(step_toward(32'(amp_q), 32'(amp_tgt)));
            end
            if (tick && active_q) begin
                per_q <= PER_W'(step_toward(32'(per_q), 32'(per_tgt)));
            end
        end
    end

    assign bus.state    = state_q;
    assign bus.amp      = amp_q;
    assign bus.rock_per = per_q;
    assign bus.active   = active_q;

endmodule

// File: doc/rock_controller.md
# rock_controller

Parametrised rocking controller: turns the DSP cry-volume stream and the heartbeat pulse into slew-limited amplitude and period codes for the output stage. It replaces the fixed-function controller between the cry/heart front-ends and the power-stage driver. It adds an explicit rocking state machine, amplitude ramps, calm-down hysteresis and optional heart-rate tracking of the rocking period.

## Interface
Parameters:
- VOL_W, 8, cry-volume sample width
- AMP_W, 8, amplitude code width
- PER_W, 8, rocking-period code width
- AMP_MAX, 8'd200, amplitude held while rocking
- CRY_THRESH, 8'd64, sample >= this counts as crying
- CALM_SAMPLES, 16, consecutive calm samples before ramp-down
- STEP_DIV, 1024, clk cycles per slew tick (>= 2)
- PER_FIXED, 8'd32, default/fallback period code
- PER_MIN, 8'd8, lower clamp on tracked period
- HP_W, 24, heart-period counter width
- PER_SHIFT, 16, right shift from heart period (cycles) to period code

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- vol_valid  in  1  one-cycle strobe, vol valid
- vol  in  VOL_W  unsigned cry volume
- heart_pulse  in  1  one-cycle pulse per heartbeat, synchronous to clk
- enable  in  1  rocking permitted
- amp  out  AMP_W  amplitude code to output stage
- rock_per  out  PER_W  rocking-period code to output stage
- state  out  2  FSM state (IDLE=0, RAMP_UP=1, ROCK=2, RAMP_DOWN=3)
- active  out  1  high whenever state != IDLE

## Operation
- Cry detect: on vol_valid, cry = (vol >= CRY_THRESH). A cry sample clears calm_cnt; a calm sample increments calm_cnt, which saturates at CALM_SAMPLES. calm_cnt is updated only on vol_valid.
- Slew tick: free-running counter 0..STEP_DIV-1 from reset. tick = 1 for one cycle when the count is STEP_DIV-1.
- FSM:
  - IDLE: amp target 0. Go to RAMP_UP on a cry sample with enable=1.
  - RAMP_UP: target AMP_MAX. Go to ROCK when amp==AMP_MAX. Go to RAMP_DOWN when calm_cnt reaches CALM_SAMPLES.
  - ROCK: hold. Go to RAMP_DOWN when calm_cnt reaches CALM_SAMPLES.
  - RAMP_DOWN: target 0. A cry sample with enable=1 sends it to RAMP_UP. Go to IDLE when amp==0.
  - enable=0 forces any state other than IDLE to RAMP_DOWN, and blocks re-entry to RAMP_UP. enable=0 has priority over a simultaneous cry.
- Amplitude: on tick only, amp moves 1 LSB toward the current target. It never overshoots and never wraps.
- Period: rock_per moves 1 LSB toward per_target on tick, only while active. It holds its value in IDLE.
- per_target is PER_FIXED unless tracking is compiled in and the heart measurement is valid (see Configuration).

## Timing
- Reset values: amp=0, rock_per=PER_FIXED, state=IDLE, active=0, calm_cnt=0, tick counter=0, heart measurement invalid.
- FSM registers its transition on the clock edge after the qualifying vol_valid cycle, so state changes 1 cycle after the strobe.
- The first amp step happens on the first tick after entering RAMP_UP. A full ramp 0->AMP_MAX takes AMP_MAX ticks.
- A calm_cnt saturation and a cry sample cannot coincide because they come from the same strobe. The cry sample clears calm_cnt.
- When amp reaches its target in the same cycle the FSM evaluates, the transition (ROCK or IDLE) happens on the next edge.
- Asserting reset mid-ramp returns all outputs to their reset values immediately (asynchronous reset).

## Configuration
- Macro ROCK_HEART_TRACK_EN.
- Defined: the heart_period_meter is instantiated.
  - It counts clk cycles between heart_pulse edges. The counter saturates at all-ones.
  - Saturation marks the measurement invalid. A valid measurement needs two pulses without an intervening saturation.
  - If a pulse and saturation occur in the same cycle, the pulse wins.
  - When valid, per_target = clamp(period >> PER_SHIFT, PER_MIN, 2^PER_W-1). When invalid, per_target = PER_FIXED.
- Not defined: no meter is built, heart_pulse is ignored, per_target = PER_FIXED and rock_per is constant PER_FIXED.

## Structure
- Shared package rock_pkg contains:
  - rock_state_t enum (IDLE, RAMP_UP, ROCK, RAMP_DOWN, 2 bits)
  - state encoding constants
- One sub-module, heart_period_meter (clk, reset, heart_pulse -> period[HP_W], period_valid), compiled in only under ROCK_HEART_TRACK_EN.

## Test plan
Bench parameters: STEP_DIV=4, AMP_MAX=8, CALM_SAMPLES=4, CRY_THRESH=64, PER_SHIFT=4, PER_FIXED=32.
- After reset, feed vol=10 samples for 100 cycles -> state=IDLE, amp=0, active=0, rock_per=32.
- One vol=100 sample -> state=RAMP_UP next cycle; amp rises by 1 every 4 cycles; state=ROCK after amp==8 (32 cycles).
- In ROCK, feed 3 calm samples, then 1 cry, then 4 calm -> stays ROCK until the 4th consecutive calm sample, then RAMP_DOWN; amp falls to 0; then IDLE.
- During RAMP_DOWN at amp=4, one cry sample -> RAMP_UP, amp resumes from 4 upward without discontinuity.
- In ROCK, drop enable while presenting vol=200 -> RAMP_DOWN, then IDLE; a cry with enable=0 leaves the block in IDLE.
- With ROCK_HEART_TRACK_EN defined, heart_pulse every 320 cycles while active -> per_target=20 and rock_per slews 32->20. Then stop the pulses until the meter saturates -> rock_per slews back to 32.
- Assert reset mid-RAMP_UP -> amp=0 and state=IDLE in the same cycle.
